// File: rtl/ushift_pkg.sv
// Shared constants for the universal shift register:
// manual mode codes, frame FSM states and per-bit mux selects.
package ushift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    // Next-value source for one bit cell
    localparam logic [1:0] SEL_HOLD  = 2'd0;
    localparam logic [1:0] SEL_PAR   = 2'd1;
    localparam logic [1:0] SEL_LEFT  = 2'd2;
    localparam logic [1:0] SEL_RIGHT = 2'd3;

endpackage

// File: rtl/ushift_cell.sv
// One bit of the shift register: 4:1 next-value mux
// feeding a synchronously reset flop.
module ushift_cell
    import ushift_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_sel,
    input  logic       i_par,
    input  logic       i_left,
    input  logic       i_right,
    output logic       o_q
);

    logic w_next;

    // Pick hold, parallel, lower-neighbour or upper-neighbour value
    always_comb begin
        w_next = o_q;
        case (i_sel)
            SEL_PAR:   w_next = i_par;
            SEL_LEFT:  w_next = i_left;
            SEL_RIGHT: w_next = i_right;
            default:   w_next = o_q;
        endcase
    end

    // Storage flop, reset clears the bit
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= 1'b0;
        end else begin
            o_q <= w_next;
        end
    end

endmodule

// File: rtl/ushift_reg.sv
// Universal shift register with manual ops and a
// start-triggered MSB-first serial frame engine.
module ushift_reg
    import ushift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_sel;
    logic [WIDTH-1:0] w_par;
    logic             w_lin;
    logic             w_rin;
    logic             w_last;

    assign w_last = (r_state == ST_FRAME)
                 && (r_cnt == CNT_W'(WIDTH - 1));

    // Per-bit select decode and chain-end sources
    always_comb begin
        w_sel = SEL_HOLD;
        w_par = pdata;
        w_lin = sin_l;
        w_rin = sin_r;
        if (en) begin
            if (r_state == ST_FRAME) begin
                w_sel = SEL_LEFT;
            end else if (start) begin
                w_sel = SEL_PAR;
            end else begin
                case (mode)
                    MODE_LOAD: w_sel = SEL_PAR;
                    MODE_SHL:  w_sel = SEL_LEFT;
                    MODE_SHR:  w_sel = SEL_RIGHT;
                    MODE_ROTL: begin
                        w_sel = SEL_LEFT;
                        w_lin = q[WIDTH-1];
                    end
                    MODE_ROTR: begin
                        w_sel = SEL_RIGHT;
                        w_rin = q[0];
                    end
                    MODE_CLR: begin
                        w_sel = SEL_PAR;
                        w_par = '0;
                    end
                    default:   w_sel = SEL_HOLD;
                endcase
            end
        end
    end

    // Bit-cell chain; ends take serial input or wrap
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_l;
        logic w_r;
        if (i == 0) begin : g_lo
            assign w_l = w_lin;
        end else begin : g_lo
            assign w_l = q[i-1];
        end
        if (i == WIDTH - 1) begin : g_hi
            assign w_r = w_rin;
        end else begin : g_hi
            assign w_r = q[i+1];
        end
        ushift_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .i_sel   (w_sel),
            .i_par   (w_par[i]),
            .i_left  (w_l),
            .i_right (w_r),
            .o_q     (q[i])
        );
    end

    // Frame FSM, shift counter, busy and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (en) begin
                if (r_state == ST_IDLE) begin
                    if (start) begin
                        r_state <= ST_FRAME;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: doc/ushift_reg.md
# ushift_reg

Parametrised universal shift register that replaces the fixed serial/parallel data cell chain. It provides WIDTH bits of hold, parallel load, shift left/right, rotate and clear. It also contains a built-in frame engine: one `start` pulse loads a parallel word, then shifts it out MSB-first over WIDTH cycles while capturing serial input, and signals completion. The block sits between the switch/bus parallel side and serial links, for example the 7-segment or serial-transfer paths.

## Interface
Parameters:
- `WIDTH`, default 8: register width in bits. Must be ≥ 2.
- `CNT_W`, default `$clog2(WIDTH)`: frame counter width. Derived; do not override.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: clock enable for all register, counter and FSM updates except `done` clearing.
- `mode` in 3: manual operation select; values are listed under Operation.
- `sin_l` in 1: serial bit entering q[0] on shift-left and in frame mode.
- `sin_r` in 1: serial bit entering q[WIDTH-1] on shift-right.
- `pdata` in WIDTH: parallel load data.
- `start` in 1: request a frame transfer. Sampled only in IDLE.
- `q` out WIDTH: register contents.
- `sout_l` out 1: q[WIDTH-1], combinational from q.
- `sout_r` out 1: q[0], combinational from q.
- `busy` out 1: frame in progress (registered).
- `done` out 1: one-cycle pulse when a frame completes (registered).

## Operation
- States: IDLE and FRAME.
- Reset: q=0, busy=0, done=0, count=0, state=IDLE. Reset has priority over `en`.
- IDLE with en=1 and start=1: q<=pdata, count<=0, state<=FRAME, busy<=1. `start` takes priority over `mode`.
- IDLE with en=1 and start=0: apply `mode`:
  - 000 hold
  - 001 load: q<=pdata
  - 010 shl: q<={q[W-2:0], sin_l}
  - 011 shr: q<={sin_r, q[W-1:1]}
  - 100 rotl: q<={q[W-2:0], q[W-1]}
  - 101 rotr: q<={q[0], q[W-1:1]}
  - 110 clear: q<=0
  - 111 reserved, behaves as hold
- FRAME with en=1: q<=shl (using sin_l), count<=count+1.
  - When count==WIDTH-1 on this edge: state<=IDLE, busy<=0, done<=1.
- FRAME ignores `mode` and `start`. A `start` asserted during FRAME is dropped, not queued.
- en=0: q, count, state and busy hold. `done` still clears on the next edge, so it is never stretched.
- `done` is cleared on every edge where it was not set by frame completion.

## Timing
- Manual ops: latency 1. `mode` is sampled at edge N and q changes after edge N.
- Frame with no stalls: start is sampled at edge E0. Shifts occur at edges E0+1 … E0+WIDTH.
- `busy` is high from after E0 through edge E0+WIDTH. `done` is high for the single cycle after E0+WIDTH.
- `sout_l` shows pdata[WIDTH-1] after E0, then pdata[WIDTH-2] after E0+1, and so on. Sample `sout_l` before each shift edge.
- After the frame, q holds the WIDTH sin_l bits captured at E0+1 … E0+WIDTH, with the first-captured bit at the MSB.
- Each en=0 cycle inside a frame delays the frame end by one cycle.
- `start` accepted in the cycle in which `done` is high begins a new frame normally. `done` still deasserts on the next edge.
- `rst` mid-frame: next cycle is IDLE with q=0, and no `done` is produced.

## Structure
- Package `ushift_pkg` holds:
  - mode constants MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_CLR
  - the state enum (ST_IDLE, ST_FRAME)
- Sub-module `ushift_cell`: one bit consisting of a 4:1 next-value mux (hold, parallel, left-neighbour, right-neighbour) and a synchronous-reset flop. It is instantiated WIDTH times in a generate loop.
- The top module holds the FSM, the counter, the per-bit select decode, and the end-of-chain wiring for shift versus rotate.

## Test plan
- Reset: q=0xFF, busy=0; assert rst for 1 cycle with en=0 → q=0x00, busy=0, done=0.
- Manual ops, WIDTH=8: load 0xA5 → 0xA5; shl with sin_l=1 → 0x4B; shr with sin_r=0 → 0x25; rotl → 0x4A; rotr → 0x25; clear → 0x00; mode 111 → q unchanged.
- Frame: pdata=0xC3, start for 1 cycle, sin_l driven with 0x5A MSB-first → `sout_l` sequence 1,1,0,0,0,0,1,1; busy high for 8 cycles after the load edge; done high exactly 1 cycle; final q=0x5A.
- Stall: as the frame test, but with en=0 for 3 cycles after the 4th shift → q and busy hold during the stall, done arrives 3 cycles later, final q is still 0x5A.
- Interference:
  - start pulsed and mode=110 toggled mid-frame → ignored; frame result unchanged.
  - start asserted in the done cycle → new frame loads, busy=1 on the next cycle.
- Reset mid-frame: rst after 3 shifts → q=0x00, busy=0, done never asserts; a subsequent start runs a full frame correctly.
